// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: read-return owner
// encoding, RISC-V funct3 access sizes and the default core burst limit.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    EXT  = 2'd2
  } owner_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam int STREAK_W               = 4;
  localparam int DEFAULT_MAX_CORE_BURST = 4;

endpackage

// File: rtl/dmem_port_arbiter_streak.sv
// Saturating count of consecutive contended core grants; limit_hit tells the
// arbiter it is the external requester's turn.
module arb_streak_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = DEFAULT_MAX_CORE_BURST
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  logic [STREAK_W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {STREAK_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign limit_hit = (count == LIMIT[STREAK_W-1:0]);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single synchronous data-memory port: core MEM
// stage has priority, the external port is guaranteed a slot after a core burst.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MAX_CORE_BURST = DEFAULT_MAX_CORE_BURST
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_size,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [2:0]        ext_size,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   limit_hit;
  logic   streak_clr;
  logic   streak_inc;
  owner_e rd_owner;
  owner_e rd_owner_next;

  arb_streak_counter #(
    .LIMIT(MAX_CORE_BURST)
  ) u_streak (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (streak_clr),
    .inc      (streak_inc),
    .limit_hit(limit_hit)
  );

  // Grants are masked during reset so nothing reaches memory while rstn is low.
  always_comb begin
    core_gnt   = rstn & core_req & (~ext_req | ~limit_hit);
    ext_gnt    = rstn & ext_req & (~core_req | limit_hit);
    core_stall = core_req & ~core_gnt;
    streak_clr = ext_gnt | ~ext_req;
    streak_inc = core_gnt & ext_req;
  end

  always_comb begin
    mem_en    = core_gnt | ext_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_size  = core_size;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_size  = ext_size;
    end
  end

  always_comb begin
    rd_owner_next = NONE;
    if (core_gnt && !core_we) begin
      rd_owner_next = CORE;
    end else if (ext_gnt && !ext_we) begin
      rd_owner_next = EXT;
    end
  end

  // Read data returns one cycle after the grant; remember who it belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_owner <= NONE;
    end else begin
      rd_owner <= rd_owner_next;
    end
  end

  always_comb begin
    core_rvalid = (rd_owner == CORE);
    ext_rvalid  = (rd_owner == EXT);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    ext_rdata   = ext_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a one-cycle-latency memory model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [2:0]    core_size;
  logic          core_gnt, core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [2:0]    ext_size;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_size;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_CORE_BURST(4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_size  (core_size),
    .core_gnt   (core_gnt),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_size   (ext_size),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: writes land on the strobe edge, read data appears one cycle later.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (!rstn) mem[8] <= 64'hDEAD_BEEF;
    if (mem_en && mem_we) mem[mem_addr[12:3]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[12:3]];
  end

  // External payload must stay put while it is waiting for a grant.
  logic          pend = 1'b0;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [2:0]    p_size;
  always @(posedge clk) begin
    if (pend && ext_req) begin
      assert ({ext_we, ext_addr, ext_wdata, ext_size} === {p_we, p_addr, p_wdata, p_size})
      else begin
        errors++;
        $error("FAIL ext_payload_stable: payload changed while waiting for ext_gnt");
      end
    end
    pend    <= rstn && ext_req && !ext_gnt;
    p_we    <= ext_we;
    p_addr  <= ext_addr;
    p_wdata <= ext_wdata;
    p_size  <= ext_size;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [2:0] size);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wdata; core_size = size;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [2:0] size);
    ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = wdata; ext_size = size;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_e;

    // Reset held with both requesters active
    rstn = 1'b0;
    set_core(1'b1, 1'b1, 64'h200, 64'hA, F3_SD);
    set_ext(1'b1, 1'b1, 64'h300, 64'hB, F3_SW);
    tick();
    tick();
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_ext_rvalid", ext_rvalid, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_ext_rdata", ext_rdata, 0);

    rstn = 1'b1;
    #1;
    chk("rel_core_gnt", core_gnt, 1);
    chk("rel_ext_gnt", ext_gnt, 0);
    chk("rel_mem_addr", mem_addr, 64'h200);
    chk("rel_mem_we", mem_we, 1);
    tick();

    // Core-only load from 0x40
    set_ext(1'b0, 1'b1, 64'h300, 64'hB, F3_SW);
    set_core(1'b1, 1'b0, 64'h40, 64'h0, F3_LD);
    #1;
    chk("ld_core_gnt", core_gnt, 1);
    chk("ld_mem_en", mem_en, 1);
    chk("ld_mem_we", mem_we, 0);
    chk("ld_mem_addr", mem_addr, 64'h40);
    chk("ld_mem_size", mem_size, F3_LD);
    tick();
    chk("ld_core_rvalid", core_rvalid, 1);
    chk("ld_core_rdata", core_rdata, 64'hDEAD_BEEF);
    chk("ld_ext_rvalid", ext_rvalid, 0);
    chk("ld_ext_rdata", ext_rdata, 0);

    // Continuous contention: C,C,C,C,E repeating
    set_core(1'b1, 1'b1, 64'h200, 64'hA, F3_SD);
    set_ext(1'b1, 1'b1, 64'h300, 64'hB, F3_SW);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_e = ((i % 5) == 4);
      chk("cont_core_gnt", core_gnt, !exp_e);
      chk("cont_ext_gnt", ext_gnt, exp_e);
      chk("cont_core_stall", core_stall, exp_e);
      chk("cont_mem_addr", mem_addr, exp_e ? 64'h300 : 64'h200);
      chk("cont_mem_wdata", mem_wdata, exp_e ? 64'hB : 64'hA);
      chk("cont_mem_size", mem_size, exp_e ? F3_SW : F3_SD);
      tick();
    end

    // External write then core load of the same location
    set_core(1'b0, 1'b1, 64'h200, 64'hA, F3_SD);
    set_ext(1'b1, 1'b1, 64'h1000, 64'h55, F3_SB);
    #1;
    chk("wr_ext_gnt", ext_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 64'h1000);
    chk("wr_mem_wdata", mem_wdata, 64'h55);
    chk("wr_mem_size", mem_size, F3_SB);
    tick();
    chk("wr_ext_rvalid", ext_rvalid, 0);
    set_ext(1'b0, 1'b1, 64'h1000, 64'h55, F3_SB);
    set_core(1'b1, 1'b0, 64'h1000, 64'h0, F3_LB);
    #1;
    chk("rd_core_gnt", core_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    tick();
    chk("rd_core_rvalid", core_rvalid, 1);
    chk("rd_core_rdata", core_rdata, 64'h55);

    // External read followed by a reset pulse
    set_core(1'b0, 1'b1, 64'h200, 64'hA, F3_SD);
    set_ext(1'b1, 1'b0, 64'h40, 64'h0, F3_LD);
    #1;
    chk("er_ext_gnt", ext_gnt, 1);
    tick();
    ext_req = 1'b0;
    rstn = 1'b0;
    #1;
    chk("er_rst_ext_rvalid", ext_rvalid, 0);
    chk("er_rst_ext_rdata", ext_rdata, 0);
    tick();
    rstn = 1'b1;
    #1;
    chk("er_post_ext_rvalid", ext_rvalid, 0);
    tick();
    chk("er_post2_ext_rvalid", ext_rvalid, 0);
    chk("er_post2_ext_rdata", ext_rdata, 0);
    chk("er_post2_core_rvalid", core_rvalid, 0);

    // External drops out mid-burst; streak restarts on reassert
    set_core(1'b1, 1'b1, 64'h200, 64'hC, F3_SD);
    set_ext(1'b1, 1'b1, 64'h300, 64'hD, F3_SW);
    #1;
    chk("drop_core_gnt0", core_gnt, 1);
    tick();
    chk("drop_core_gnt1", core_gnt, 1);
    tick();
    ext_req = 1'b0;
    #1;
    chk("drop_core_gnt2", core_gnt, 1);
    tick();
    ext_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_e = (i == 4);
      chk("reass_core_gnt", core_gnt, !exp_e);
      chk("reass_ext_gnt", ext_gnt, exp_e);
      chk("reass_core_stall", core_stall, exp_e);
      tick();
    end

    set_core(1'b0, 1'b1, 64'h0, 64'h0, F3_SD);
    set_ext(1'b0, 1'b1, 64'h0, 64'h0, F3_SD);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data-memory port between two requesters.
- Requester 0 is the core MEM stage: high priority, stalls the pipeline when refused.
- Requester 1 is the external port: memory-mapped peripheral DMA / debug loader, low priority.
- Bounded starvation counter guarantees the external port progress while the core streams loads/stores.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MAX_CORE_BURST, 4, consecutive contended core grants before one forced external grant (legal range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
core_req  in  1  core MEM stage access request (mwmem or mm2reg)
core_we  in  1  1 = store, 0 = load
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  store data
core_size  in  3  funct3 access size/sign
core_gnt  out  1  access accepted this cycle
core_stall  out  1  core_req & ~core_gnt; freezes PC, IF/ID and downstream regs
core_rvalid  out  1  load data valid (cycle after load grant)
core_rdata  out  DATA_W  load data
ext_req  in  1  external request; payload held stable until ext_gnt
ext_we  in  1  1 = write
ext_addr  in  ADDR_W  byte address
ext_wdata  in  DATA_W  write data
ext_size  in  3  funct3 encoding
ext_gnt  out  1  accepted this cycle
ext_rvalid  out  1  read data valid
ext_rdata  out  DATA_W  read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_size  out  3  size to memory
mem_rdata  in  DATA_W  memory read data, valid exactly 1 cycle after a read strobe

Behaviour:
- Reset (rstn low, async): streak=0, rd_owner=NONE. All outputs 0: gnt, rvalid, rdata, mem_en.
- Grant logic is combinational from the requests and registered streak. At most one grant per cycle.
  - core_req only: core_gnt=1.
  - ext_req only: ext_gnt=1.
  - Both requesting, streak < MAX_CORE_BURST: core wins.
  - Both requesting, streak == MAX_CORE_BURST: ext wins and core stalls one cycle.
- Streak counter (saturating, 4 bits), next-state priority order:
  - ext granted: clear to 0.
  - core granted while ext_req=1: increment.
  - ext_req=0: clear to 0.
- Memory mux:
  - mem_* driven from the granted requester.
  - mem_en = core_gnt | ext_gnt.
  - With no grant: mem_we=0; address, data and size are don't-care but held 0.
- Read return:
  - rd_owner registered each cycle: CORE, EXT or NONE. Set from a read grant (we=0); writes and idle give NONE.
  - core_rvalid = (rd_owner==CORE). ext_rvalid = (rd_owner==EXT).
  - Each rdata = mem_rdata when its rvalid is 1, else 0.
- Read latency: 1 cycle after grant. Write latency: the grant cycle. Back-to-back grants are legal every cycle with no bubble.
- Sign/size extension is not done here; the size field passes through untouched.
- Reset mid-operation:
  - A pending read is discarded; no rvalid after rstn rises.
  - The first grant after reset follows the normal rules with streak=0.
- Requester dropping req without a grant is legal (no side effects). Changing payload while req=1 and ungranted is a protocol violation: bench asserts, RTL need not handle.

Decomposition:
- Shared package:
  - Owner encoding: NONE=2'd0, CORE=2'd1, EXT=2'd2.
  - funct3 size constants: LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD.
  - Default MAX_CORE_BURST.
- One natural sub-module: arb_streak_counter (saturating counter with clear/inc, exposes limit_hit).

Test Plan:
- Reset: hold rstn=0 with both reqs=1 -> all gnt/rvalid/mem_en 0; release -> core_gnt=1 on first edge, streak=1.
- Core-only load addr 0x40, mem returns 0xDEADBEEF -> core_gnt cycle N, core_rvalid=1 and core_rdata=0xDEADBEEF at N+1, ext_rvalid=0.
- Contention, both req continuously, MAX=4 -> grant pattern C,C,C,C,E repeating; core_stall=1 exactly on E cycles.
- Ext write 0x1000=0x55 then core load 0x1000 next cycle, no contention -> mem_we=1 then 0, core_rdata=0x55 one cycle later.
- Ext read granted in cycle N, rstn pulsed low in N+1 -> ext_rvalid stays 0, no stale rdata after reset.
- Ext_req drops after 2 contended core grants, reasserts -> streak restarted at 0; ext waits 4 core grants again.
